fir_dout_pack: RTL and testbench

- Consumes the filtered sample stream (yvld/yout) from the FIR stage. Decimates it by a runtime ratio and packs PACK_NUM samples into one wide word.
- Buffers packed words in a small first-word-fall-through FIFO. The downstream DMA/upload logic drains it with a valid/ready handshake.
- Single clock domain: the FIR processing clock.

---
 rtl/fir_dout_pack.sv | 187 ++++++++++++++++++
 tb/tb_fir_dout_pack.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fir_dout_pack.sv
// Decimates the FIR sample stream, packs PACK_NUM sign-extended 16-bit lanes per word and queues the words in a FWFT FIFO.
// Latency: 2 cycles from the yvld of the last lane to dout_vld (staging register, then FIFO write).
// Backpressure: dout_vld/dout_rdy drains the FIFO; a word completed while the FIFO is full is dropped and ovf_flag is set.

module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic [AW:0]   cnt
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // full is judged on the registered count, so a same-cycle pop never makes room
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_vld && rd_rdy;
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module fir_dout_pack #(
    parameter int YDATA_WDTH = 14,
    parameter int PACK_NUM   = 4,
    parameter int DEC_WDTH   = 8,
    parameter int FIFO_AW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pack_en,
    input  logic [DEC_WDTH-1:0]    dec_ratio,
    input  logic                   yvld,
    input  logic [YDATA_WDTH-1:0]  yout,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic [PACK_NUM*16-1:0] dout,
    output logic                   dout_last,
    output logic [FIFO_AW:0]       fifo_cnt,
    output logic                   ovf_flag,
    input  logic                   ovf_clr
);
    localparam int LW     = 16;
    localparam int WW     = PACK_NUM * LW;
    localparam int LANE_W = $clog2(PACK_NUM + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t              state;
    logic [DEC_WDTH-1:0] ratio_q;
    logic [DEC_WDTH-1:0] dec_cnt;
    logic [LANE_W-1:0]   lane_cnt;
    logic [WW-1:0]       pack_dat;
    logic                stg_vld;
    logic                stg_last;
    logic [WW-1:0]       stg_dat;
    logic                fifo_full;
    logic [LW-1:0]       samp_ext;
    logic [WW-1:0]       pack_ins;
    logic                keep;
    logic                lane_done;

    assign samp_ext  = {{(LW-YDATA_WDTH){yout[YDATA_WDTH-1]}}, yout};
    assign keep      = (state == S_RUN) && yvld && (dec_cnt == '0);
    assign lane_done = keep && (lane_cnt == LANE_W'(PACK_NUM - 1));

    always_comb begin
        pack_ins = pack_dat;
        pack_ins[int'(lane_cnt)*LW +: LW] = samp_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ratio_q  <= DEC_WDTH'(1);
            dec_cnt  <= '0;
            lane_cnt <= '0;
            pack_dat <= '0;
            stg_vld  <= 1'b0;
            stg_last <= 1'b0;
            stg_dat  <= '0;
            ovf_flag <= 1'b0;
        end else begin
            stg_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pack_en) begin
                        state    <= S_RUN;
                        ratio_q  <= (dec_ratio == '0) ? DEC_WDTH'(1) : dec_ratio;
                        dec_cnt  <= '0;
                        lane_cnt <= '0;
                        pack_dat <= '0;
                    end
                end
                S_RUN: begin
                    if (yvld) begin
                        dec_cnt <= (dec_cnt == ratio_q - DEC_WDTH'(1)) ? '0 : dec_cnt + DEC_WDTH'(1);
                    end
                    if (lane_done) begin
                        stg_vld  <= 1'b1;
                        stg_last <= 1'b0;
                        stg_dat  <= pack_ins;
                        lane_cnt <= '0;
                        pack_dat <= '0;
                    end else if (keep) begin
                        pack_dat <= pack_ins;
                        lane_cnt <= lane_cnt + LANE_W'(1);
                    end
                    if (!pack_en) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // unfilled lanes are already zero because pack_dat clears on every word
                    if (lane_cnt != '0) begin
                        stg_vld  <= 1'b1;
                        stg_last <= 1'b1;
                        stg_dat  <= pack_dat;
                        lane_cnt <= '0;
                        pack_dat <= '0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (stg_vld && fifo_full) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DW (WW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (stg_vld),
        .wr_dat ({stg_last, stg_dat}),
        .rd_vld (dout_vld),
        .rd_rdy (dout_rdy),
        .rd_dat ({dout_last, dout}),
        .full   (fifo_full),
        .cnt    (fifo_cnt)
    );
endmodule

// File: tb/tb_fir_dout_pack.sv
// Directed bench for fir_dout_pack: packing, sign extension, decimation, flush, overflow/backpressure and async reset.
module tb_fir_dout_pack;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pack_en;
    logic [7:0]  dec_ratio;
    logic        yvld;
    logic [13:0] yout;
    logic        dout_vld;
    logic        dout_rdy;
    logic [63:0] dout;
    logic        dout_last;
    logic [4:0]  fifo_cnt;
    logic        ovf_flag;
    logic        ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    fir_dout_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pack_en   (pack_en),
        .dec_ratio (dec_ratio),
        .yvld      (yvld),
        .yout      (yout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout      (dout),
        .dout_last (dout_last),
        .fifo_cnt  (fifo_cnt),
        .ovf_flag  (ovf_flag),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] v);
        yvld = 1'b1;
        yout = v;
        tick();
        yvld = 1'b0;
    endtask

    task automatic pop();
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
    endtask

    task automatic to_idle();
        pack_en = 1'b0;
        tick();
        tick();
        tick();
    endtask

    function automatic logic [63:0] word4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    initial begin
        logic [63:0] exp_w;
        rst_n = 1'b0; pack_en = 1'b0; dec_ratio = 8'd1; yvld = 1'b0; yout = '0;
        dout_rdy = 1'b0; ovf_clr = 1'b0;
        #12;
        check("rst_vld", dout_vld, 0);
        check("rst_dout", dout, 0);
        check("rst_last", dout_last, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_ovf", ovf_flag, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic pack and 2-cycle latency
        pack_en = 1'b1; dec_ratio = 8'd1;
        tick();
        send(14'd1); send(14'd2); send(14'd3); send(14'd4);
        check("lat_1cyc_vld", dout_vld, 0);
        tick();
        check("lat_2cyc_vld", dout_vld, 1);
        check("basic_dout", dout, 64'h0004_0003_0002_0001);
        check("basic_last", dout_last, 0);
        check("basic_cnt", fifo_cnt, 1);
        pop();
        check("basic_popped", fifo_cnt, 0);

        // sign extension across lanes
        send(14'h2000); send(14'h3FFF); send(14'h1FFF); send(14'd5);
        tick();
        check("sext_dout", dout, 64'h0005_1FFF_FFFF_E000);
        pop();

        // decimation by 3 keeps 0,3,6,9
        to_idle();
        check("empty_flush_cnt", fifo_cnt, 0);
        dec_ratio = 8'd3; pack_en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) send(14'(i));
        tick();
        check("dec3_cnt", fifo_cnt, 1);
        check("dec3_dout", dout, word4(0, 3, 6, 9));
        pop();

        // ratio 0 behaves as ratio 1
        to_idle();
        dec_ratio = 8'd0; pack_en = 1'b1;
        tick();
        send(14'd7); send(14'd8); send(14'd9); send(14'd10);
        tick();
        check("dec0_dout", dout, word4(7, 8, 9, 10));
        pop();

        // flush of a partial word
        to_idle();
        dec_ratio = 8'd1; pack_en = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) send(14'(i));
        to_idle();
        check("flush_cnt", fifo_cnt, 2);
        check("flush_w1", dout, word4(1, 2, 3, 4));
        check("flush_w1_last", dout_last, 0);
        pop();
        check("flush_w2", dout, word4(5, 6, 0, 0));
        check("flush_w2_last", dout_last, 1);
        pop();
        check("flush_drained", dout_vld, 0);
        send(14'd99);
        tick(); tick();
        check("idle_ignores", fifo_cnt, 0);

        // overflow with backpressure, then ordered drain
        pack_en = 1'b1;
        tick();
        for (int i = 0; i < 68; i++) send(14'(i));
        tick(); tick();
        check("ovf_cnt", fifo_cnt, 16);
        check("ovf_flag", ovf_flag, 1);
        exp_w = word4(0, 1, 2, 3);
        check("stall_dout0", dout, exp_w);
        tick(); tick();
        check("stall_dout1", dout, exp_w);
        check("stall_cnt", fifo_cnt, 16);
        dout_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain_w%0d", k), dout, word4(4*k, 4*k+1, 4*k+2, 4*k+3));
            tick();
        end
        dout_rdy = 1'b0;
        check("drain_cnt", fifo_cnt, 0);
        check("drain_no17", dout_vld, 0);
        check("ovf_sticky", ovf_flag, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_flag, 0);

        // async reset with 5 words queued
        for (int i = 0; i < 20; i++) send(14'(i + 100));
        tick(); tick();
        check("prerst_cnt", fifo_cnt, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", dout_vld, 0);
        check("midrst_cnt", fifo_cnt, 0);
        tick();
        rst_n = 1'b1;
        pack_en = 1'b0;
        tick(); tick(); tick();
        check("postrst_vld", dout_vld, 0);
        check("postrst_dout", dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
